bus_timer_periph: RTL
=====================

BUS_TIMER_PERIPH -- requirements
Module: bus_timer_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0002_0000, window base (aligned to 256 B).
REQ-002 SHALL have parameter PRESCALE, default 8, clock cycles per timer tick (>=1).
REQ-003 SHALL have port clk_sys  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_sys_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_i in 1, we_i in 1, be_i in 4, addr_i in 32, wdata_i in 32: Ibex-style data request; initiator holds them stable until gnt_o.
REQ-006 SHALL have ports gnt_o out 1, rvalid_o out 1, rdata_o out 32, err_o out 1: grant, response valid, read data, error flag (valid with rvalid_o).
REQ-007 SHALL have ports led_o out 4 (LED register) and irq_timer_o out 1 (timer interrupt, level).

Function
REQ-008 SHALL decode hit = req_i && (addr_i[31:8] == BASE_ADDR[31:8]); req_i without hit is ignored (no gnt_o).
REQ-009 SHALL implement FSM IDLE -> GRANT -> RESP -> IDLE; IDLE->GRANT on hit, GRANT->RESP and RESP->IDLE unconditionally.
REQ-010 SHALL register we_i, be_i, addr_i[7:2], wdata_i on the IDLE->GRANT edge.
REQ-011 SHALL drive gnt_o=1 only in GRANT (exactly one cycle, one cycle after req_i sampled), rvalid_o=1 only in RESP (exactly one cycle, one cycle after gnt_o).
REQ-012 SHALL accept at most one outstanding request; req_i arriving in GRANT/RESP waits, accepted in next IDLE (max throughput 1 per 3 cycles).
REQ-013 SHALL map offsets: 0x00 LED[3:0], 0x04 MTIME_LO, 0x08 MTIME_HI, 0x0C MTIMECMP_LO, 0x10 MTIMECMP_HI, 0x14 CTRL (bit0 timer_en, bit1 irq_en); unused bits read 0, writes ignored.
REQ-014 SHALL apply writes on the GRANT->RESP edge, per byte lane where be=1; be=4'b0000 write changes nothing but still completes.
REQ-015 SHALL capture rdata_o on the GRANT->RESP edge and hold it 0 when rvalid_o=0 or on writes.
REQ-016 SHALL complete any in-window offset >= 0x18 with err_o=1, rdata_o=0, no state change.
REQ-017 SHALL increment 64-bit mtime by 1 per tick while timer_en=1, wrapping 2^64-1 -> 0 with no flag.
REQ-018 SHALL give a software write to MTIME_LO/HI priority over a same-cycle increment; written value is loaded, untouched half keeps its current value (no carry into it that cycle).
REQ-019 SHALL drive irq_timer_o as registered (irq_en && mtime >= mtimecmp), 64-bit unsigned compare, updated every cycle, 1-cycle latency after the condition.
REQ-020 SHALL deassert irq_timer_o the cycle after software raises MTIMECMP above mtime or clears irq_en.
REQ-021 SHALL drive led_o directly from LED register (no extra latency beyond the write edge).

Reset
REQ-022 SHALL, on rst_sys_n low, immediately force FSM to IDLE and gnt_o, rvalid_o, err_o, irq_timer_o = 0, rdata_o = 0, led_o = 0.
REQ-023 SHALL reset mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, prescaler counter=0.
REQ-024 SHALL discard an in-flight request when reset asserts mid-transaction; no write takes effect, no response issued.

Configuration
REQ-025 SHALL honour macro BUS_TIMER_PRESCALER_EN: defined -> tick when prescaler counter reaches PRESCALE-1, counter then wraps to 0 and only counts while timer_en=1; undefined -> tick every cycle, PRESCALE ignored, no counter logic.

Verification
REQ-026 SHALL cover: write 0x00=0x0000_000A be=4'b0001 -> gnt_o cycle N+1, rvalid_o N+2, err_o=0, led_o=4'hA from N+2.
REQ-027 SHALL cover: read offset 0x20 -> rvalid_o with err_o=1, rdata_o=0, registers unchanged; req_i outside window -> no gnt_o for 10 cycles.
REQ-028 SHALL cover: MTIMECMP=0:20, CTRL=3, prescaler on, PRESCALE=8 -> irq_timer_o rises 1 cycle after mtime reaches 20 (~160 cycles after enable); writing MTIMECMP_LO=100 clears it next cycle.
REQ-029 SHALL cover: MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, timer_en -> after one tick MTIME_HI reads 1, MTIME_LO reads 0; also write MTIME_LO on a tick cycle -> written value wins.
REQ-030 SHALL cover: req_i held continuously with two back-to-back requests -> second gnt_o exactly 3 cycles after first; rst_sys_n pulsed during GRANT -> no rvalid_o, target register unchanged, led_o=0.

Source files
------------

// File: rtl/bus_timer_periph.sv
// Bus-attached LED register plus 64-bit machine timer with compare interrupt.
// Optional tick prescaler is enabled by defining BUS_TIMER_PRESCALER_EN.
module bus_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int          PRESCALE  = 8
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [3:0]  led_o,
  output logic        irq_timer_o
);

  // state | meaning
  // IDLE  | waiting for a request that hits the window
  // GRANT | request accepted, gnt_o high, write/read performed on exit
  // RESP  | rvalid_o high with captured rdata/err
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RESP} state_t;

  localparam logic [5:0] OFF_LED     = 6'd0;
  localparam logic [5:0] OFF_MT_LO   = 6'd1;
  localparam logic [5:0] OFF_MT_HI   = 6'd2;
  localparam logic [5:0] OFF_CMP_LO  = 6'd3;
  localparam logic [5:0] OFF_CMP_HI  = 6'd4;
  localparam logic [5:0] OFF_CTRL    = 6'd5;

  state_t      state_q, state_d;
  logic        hit;
  logic        we_q;
  logic [3:0]  be_q;
  logic [5:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        off_valid;
  logic        wr_en;
  logic [31:0] rd_mux;

  logic [3:0]  led_q;
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        timer_en_q;
  logic        irq_en_q;
  logic        irq_q;
  logic        tick;

  logic        unused_addr;
  assign unused_addr = ^addr_i[1:0];

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  assign hit       = req_i && (addr_i[31:8] == BASE_ADDR[31:8]);
  assign off_valid = (off_q <= OFF_CTRL);
  // be=0 writes are true no-ops, including not suppressing a timer tick
  assign wr_en     = (state_q == ST_GRANT) && we_q && off_valid && (|be_q);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hit) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = (state_q == ST_GRANT);
    rvalid_o = (state_q == ST_RESP);
    err_o    = rvalid_o && err_q;
    rdata_o  = rvalid_o ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      off_q   <= 6'h0;
      wdata_q <= 32'h0;
    end else if ((state_q == ST_IDLE) && hit) begin
      we_q    <= we_i;
      be_q    <= be_i;
      off_q   <= addr_i[7:2];
      wdata_q <= wdata_i;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (off_q)
      OFF_LED:    rd_mux = {28'h0, led_q};
      OFF_MT_LO:  rd_mux = mtime_q[31:0];
      OFF_MT_HI:  rd_mux = mtime_q[63:32];
      OFF_CMP_LO: rd_mux = mtimecmp_q[31:0];
      OFF_CMP_HI: rd_mux = mtimecmp_q[63:32];
      OFF_CTRL:   rd_mux = {30'h0, irq_en_q, timer_en_q};
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state_q == ST_GRANT) begin
      rdata_q <= (!we_q && off_valid) ? rd_mux : 32'h0;
      err_q   <= !off_valid;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      led_q      <= 4'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      timer_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else if (wr_en) begin
      case (off_q)
        OFF_LED:    if (be_q[0]) led_q <= wdata_q[3:0];
        OFF_CMP_LO: mtimecmp_q[31:0]  <= merge_be(mtimecmp_q[31:0], wdata_q, be_q);
        OFF_CMP_HI: mtimecmp_q[63:32] <= merge_be(mtimecmp_q[63:32], wdata_q, be_q);
        OFF_CTRL: if (be_q[0]) begin
          timer_en_q <= wdata_q[0];
          irq_en_q   <= wdata_q[1];
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_TIMER_PRESCALER_EN
  logic [31:0] presc_cnt_q;
  localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n)      presc_cnt_q <= 32'h0;
    else if (timer_en_q) presc_cnt_q <= (presc_cnt_q == PRESC_LAST) ? 32'h0 : presc_cnt_q + 32'h1;
  end

  assign tick = timer_en_q && (presc_cnt_q == PRESC_LAST);
`else
  // PRESCALE is legal only when >= 1, so this term is constant true
  assign tick = timer_en_q && (PRESCALE > 0);
`endif

  // a software write to either half wins over the increment in that cycle
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      mtime_q <= 64'h0;
    end else if (wr_en && (off_q == OFF_MT_LO)) begin
      mtime_q[31:0] <= merge_be(mtime_q[31:0], wdata_q, be_q);
    end else if (wr_en && (off_q == OFF_MT_HI)) begin
      mtime_q[63:32] <= merge_be(mtime_q[63:32], wdata_q, be_q);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'h1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) irq_q <= 1'b0;
    else            irq_q <= irq_en_q && (mtime_q >= mtimecmp_q);
  end

  assign led_o       = led_q;
  assign irq_timer_o = irq_q;

endmodule
